chan_arb_mux: RTL

Parametrised, registered N-channel datapath selector with valid/ready handshakes: the successor to the combinational 8-way 32-bit mux. It picks one of `NUM_CH` input channels, either from an explicit select (fixed mode) or by round-robin arbitration, and captures the winner into a single output register stage. Sits between multiple producers (e.g. writeback sources, test stimulus streams) and one consumer in the CPU datapath.

---
 rtl/chan_arb_mux.sv | 77 +++++++
 1 files changed

// File: rtl/chan_arb_mux.sv
// rtl/chan_arb_mux.sv - registered N-channel valid/ready selector with fixed or round-robin grant
module chan_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0]  ptr;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              granted;
  logic              can_load;
  int                idx;

  assign can_load = !out_valid || out_ready;

  // Round-robin scans ptr upward with wrap at NUM_CH; fixed mode ignores out-of-range sel.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    granted   = 1'b0;
    idx       = 0;
    if (!mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SEL_W'(i);
          granted   = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!granted && in_valid[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = SEL_W'(idx);
          granted    = 1'b1;
        end
      end
    end
  end

  assign in_ready = (reset_n && can_load) ? grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (can_load) begin
      if (granted) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_ch    <= grant_idx;
        if (mode)
          ptr <= (grant_idx == SEL_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
